// File: rtl/flashram_pkg.sv
// Shared types and constants for the N64 FlashRAM command engine.
package flashram_pkg;

  typedef enum logic [2:0] {
    MODE_STATUS = 3'd0,
    MODE_ID     = 3'd1,
    MODE_READ   = 3'd2,
    MODE_ERASE  = 3'd3,
    MODE_LOAD   = 3'd4,
    MODE_BUSY   = 3'd5
  } e_mode;

  localparam logic [7:0] OP_STATUS       = 8'hE1;
  localparam logic [7:0] OP_ID           = 8'h90;
  localparam logic [7:0] OP_READ         = 8'hF0;
  localparam logic [7:0] OP_ERASE_SECTOR = 8'h4B;
  localparam logic [7:0] OP_ERASE_CHIP   = 8'h3C;
  localparam logic [7:0] OP_LOAD         = 8'hB4;
  localparam logic [7:0] OP_SET_PAGE     = 8'hA5;
  localparam logic [7:0] OP_EXEC_ERASE   = 8'h78;
  localparam logic [7:0] OP_EXEC_PROGRAM = 8'hD2;

  localparam int ST_WRITE_BUSY = 0;
  localparam int ST_ERASE_BUSY = 1;
  localparam int ST_WRITE_DONE = 2;
  localparam int ST_ERASE_DONE = 3;

endpackage

// File: rtl/flashram_buffer.sv
// 32x32 page buffer: one synchronous write port (N64), one asynchronous read port (CPU).
module flashram_buffer (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reads see the pre-edge contents, so a same-cycle write to raddr returns old data.
  assign rdata = mem[raddr];

endmodule

// File: rtl/n64_flashram.sv
// N64 FlashRAM command engine: mode FSM, page buffer, status/ID reads, firmware job posting.
// Optional FLASHRAM_BUFFER_ERASE_EN: per-word valid mask so unwritten words read as erased (all ones).
module n64_flashram
  import flashram_pkg::*;
#(
  parameter logic [31:0] ID_HI = 32'h1111_8001,
  parameter logic [31:0] ID_LO = 32'h00C2_001E
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        n64_cmd_write,
  input  logic        n64_buf_write,
  input  logic [4:0]  n64_address,
  input  logic [31:0] n64_wdata,
  input  logic        n64_read,
  output logic [31:0] n64_rdata,
  output logic        n64_array_read,
  input  logic [4:0]  address,
  output logic [31:0] rdata,
  output logic [9:0]  sector,
  output logic        operation_pending,
  output logic        write_or_erase,
  output logic        sector_or_all,
  input  logic        operation_done,
  output e_mode       mode_dbg
);

  e_mode       mode_q, mode_d;
  logic [9:0]  page_q, page_d;
  logic        all_q, all_d;
  logic        clr_done, exec_go, exec_erase, load_start;
  logic        done_hit, cmd_ok, buf_we;
  logic        write_done_q, erase_done_q;
  logic [31:0] status_word, rd_mux, buf_rdata;
  logic [7:0]  opcode;

  assign opcode   = n64_wdata[31:24];
  assign done_hit = operation_done & operation_pending;
  // A completing job takes priority over any command arriving in the same cycle.
  assign cmd_ok   = n64_cmd_write & (mode_q != MODE_BUSY) & ~done_hit;
  assign buf_we   = n64_buf_write & (mode_q == MODE_LOAD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_STATUS;
      page_q <= '0;
      all_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      page_q <= page_d;
      all_q  <= all_d;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    page_d     = page_q;
    all_d      = all_q;
    clr_done   = 1'b0;
    exec_go    = 1'b0;
    exec_erase = 1'b0;
    load_start = 1'b0;
    if (done_hit) begin
      mode_d = MODE_STATUS;
    end else if (cmd_ok) begin
      case (opcode)
        OP_STATUS: begin
          mode_d   = MODE_STATUS;
          clr_done = 1'b1;
        end
        OP_ID:   mode_d = MODE_ID;
        OP_READ: mode_d = MODE_READ;
        OP_ERASE_SECTOR: begin
          mode_d = MODE_ERASE;
          page_d = n64_wdata[9:0] & 10'h380;
          all_d  = 1'b0;
        end
        OP_ERASE_CHIP: begin
          mode_d = MODE_ERASE;
          page_d = '0;
          all_d  = 1'b1;
        end
        OP_LOAD: begin
          mode_d     = MODE_LOAD;
          load_start = 1'b1;
        end
        OP_SET_PAGE: page_d = n64_wdata[9:0];
        OP_EXEC_ERASE: begin
          if (mode_q == MODE_ERASE) begin
            mode_d     = MODE_BUSY;
            exec_go    = 1'b1;
            exec_erase = 1'b1;
          end
        end
        OP_EXEC_PROGRAM: begin
          if (mode_q == MODE_LOAD) begin
            mode_d  = MODE_BUSY;
            exec_go = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Job descriptor is frozen at execute time and held until firmware reports done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operation_pending <= 1'b0;
      write_or_erase    <= 1'b0;
      sector_or_all     <= 1'b0;
      sector            <= '0;
      write_done_q      <= 1'b0;
      erase_done_q      <= 1'b0;
    end else if (exec_go) begin
      operation_pending <= 1'b1;
      write_or_erase    <= exec_erase;
      sector_or_all     <= exec_erase & all_q;
      sector            <= page_q;
      write_done_q      <= 1'b0;
      erase_done_q      <= 1'b0;
    end else if (done_hit) begin
      operation_pending <= 1'b0;
      if (write_or_erase) erase_done_q <= 1'b1;
      else                write_done_q <= 1'b1;
    end else if (clr_done) begin
      write_done_q <= 1'b0;
      erase_done_q <= 1'b0;
    end
  end

  always_comb begin
    status_word                = '0;
    status_word[ST_WRITE_BUSY] = operation_pending & ~write_or_erase;
    status_word[ST_ERASE_BUSY] = operation_pending & write_or_erase;
    status_word[ST_WRITE_DONE] = write_done_q;
    status_word[ST_ERASE_DONE] = erase_done_q;
    case (mode_q)
      MODE_STATUS, MODE_BUSY: rd_mux = status_word;
      MODE_ID:                rd_mux = n64_address[0] ? ID_LO : ID_HI;
      default:                rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      n64_rdata <= '0;
    else if (n64_read) n64_rdata <= rd_mux;
  end

  assign n64_array_read = (mode_q == MODE_READ);
  assign mode_dbg       = mode_q;

  flashram_buffer u_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (n64_address),
    .wdata (n64_wdata),
    .raddr (address),
    .rdata (buf_rdata)
  );

`ifdef FLASHRAM_BUFFER_ERASE_EN
  logic [31:0] valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      if (load_start) valid_q <= '0;
      if (buf_we)     valid_q[n64_address] <= 1'b1;
    end
  end

  assign rdata = valid_q[address] ? buf_rdata : 32'hFFFF_FFFF;
`else
  assign rdata = buf_rdata;
`endif

endmodule
